// File: rtl/bram_dualport_pkg.sv
// Shared memory types: access-size encodings, I/O base default and
// the alignment rule shared by the RAM and its checkers.
package bram_dualport_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } mem_size_e;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

    // 1 when an access of this size at this byte offset is not naturally aligned,
    // or the size code itself is illegal.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (mem_size_e'(size))
            SIZE_BYTE:    bad = 1'b0;
            SIZE_HALF:    bad = off[0];
            SIZE_WORD:    bad = (off != 2'd0);
            SIZE_ILLEGAL: bad = 1'b1;
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/bram_dualport_load_align.sv
// Port-2 load path: picks the addressed byte/half out of a RAM word and
// sign- or zero-extends it to 32 bits.
module load_align
    import bram_dualport_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    assign byte_shift = word >> {off, 3'b000};
    assign half_shift = word >> {off[1], 4'b0000};

    // sign = 1 means unsigned load, so extension bits are forced to zero.
    always_comb begin
        data = word;
        case (mem_size_e'(size))
            SIZE_BYTE: data = {{24{~sign & byte_shift[7]}}, byte_shift[7:0]};
            SIZE_HALF: data = {{16{~sign & half_shift[15]}}, half_shift[15:0]};
            default:   data = word;
        endcase
    end

endmodule

// File: rtl/bram_dualport.sv
// Dual-port block RAM: port 1 is a read-only instruction port, port 2 a
// byte-addressable data port with memory-mapped I/O above IO_BASE.
module bram_dualport
    import bram_dualport_pkg::*;
#(
    parameter int          WORD_ADDR_W = 14,
    parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT,
    parameter              INIT_FILE   = "mem.mem"
) (
    input  logic        MEM_CLK,
    input  logic        MEM_RST,
    input  logic [31:0] MEM_ADDR1,
    input  logic        MEM_READ1,
    output logic [31:0] MEM_DOUT1,
    input  logic [31:0] MEM_ADDR2,
    input  logic [31:0] MEM_DIN2,
    input  logic        MEM_WRITE2,
    input  logic        MEM_READ2,
    input  logic [1:0]  MEM_SIZE,
    input  logic        MEM_SIGN,
    output logic [31:0] MEM_DOUT2,
    input  logic [31:0] IO_IN,
    output logic        IO_WR,
    output logic        ERR
);

    localparam int DEPTH = 1 << WORD_ADDR_W;

    logic [31:0] mem [DEPTH];

    logic [WORD_ADDR_W-1:0] idx1;
    logic [WORD_ADDR_W-1:0] idx2;
    logic                   io_sel2;
    logic                   err1;
    logic                   err2;
    logic                   mem_we;
    logic [3:0]             wr_be;
    logic [31:0]            wr_data;

    logic [31:0] rd2_word;
    logic [1:0]  rd2_off;
    logic [1:0]  rd2_size;
    logic        rd2_sign;
    logic        rd2_io;
    logic [31:0] rd2_io_data;
    logic [31:0] rd2_aligned;

    // Address bits above the array are deliberately ignored (aliasing).
    logic unused_addr1_hi;
    assign unused_addr1_hi = ^MEM_ADDR1[31:WORD_ADDR_W+2];

    assign idx1    = MEM_ADDR1[WORD_ADDR_W+1:2];
    assign idx2    = MEM_ADDR2[WORD_ADDR_W+1:2];
    assign io_sel2 = (MEM_ADDR2 >= IO_BASE);

    assign err1   = MEM_READ1 && (MEM_ADDR1[1:0] != 2'd0);
    assign err2   = (MEM_READ2 || MEM_WRITE2) && size_misaligned(MEM_SIZE, MEM_ADDR2[1:0]);
    assign ERR    = err1 | err2;
    assign IO_WR  = MEM_WRITE2 && io_sel2;
    assign mem_we = MEM_WRITE2 && !io_sel2 && !err2 && !MEM_RST;

    // Right-aligned store data is replicated across lanes; the byte enables pick the lanes.
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = MEM_DIN2;
        case (mem_size_e'(MEM_SIZE))
            SIZE_BYTE: begin
                wr_be   = 4'b0001 << MEM_ADDR2[1:0];
                wr_data = {4{MEM_DIN2[7:0]}};
            end
            SIZE_HALF: begin
                wr_be   = MEM_ADDR2[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{MEM_DIN2[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = MEM_DIN2;
            end
        endcase
    end

    always_ff @(posedge MEM_CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[idx2][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Reads sample the array with non-blocking semantics, so a same-edge write is seen next cycle.
    always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
        if (MEM_RST) begin
            MEM_DOUT1   <= '0;
            rd2_word    <= '0;
            rd2_off     <= '0;
            rd2_size    <= '0;
            rd2_sign    <= 1'b0;
            rd2_io      <= 1'b0;
            rd2_io_data <= '0;
        end else begin
            if (MEM_READ1) MEM_DOUT1 <= mem[idx1];
            if (MEM_READ2) begin
                rd2_word    <= mem[idx2];
                rd2_off     <= MEM_ADDR2[1:0];
                rd2_size    <= MEM_SIZE;
                rd2_sign    <= MEM_SIGN;
                rd2_io      <= io_sel2;
                rd2_io_data <= IO_IN;
            end
        end
    end

    load_align u_load_align (
        .word (rd2_word),
        .off  (rd2_off),
        .size (rd2_size),
        .sign (rd2_sign),
        .data (rd2_aligned)
    );

    assign MEM_DOUT2 = rd2_io ? rd2_io_data : rd2_aligned;

endmodule

// File: tb/tb_bram_dualport.sv
// Bench for bram_dualport: directed vector table, reset/read-first sequences,
// then randomized traffic against a byte-level reference model.
module tb_bram_dualport;
    import bram_dualport_pkg::*;

    localparam logic [31:0] IO_BASE = IO_BASE_DEFAULT;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr1, addr2, din2, io_in;
    logic        read1, read2, write2, sign;
    logic [1:0]  size;
    logic [31:0] dout1, dout2;
    logic        io_wr, err;

    int checks = 0;
    int errors = 0;

    bram_dualport #(.WORD_ADDR_W(14), .IO_BASE(IO_BASE), .INIT_FILE("")) dut (
        .MEM_CLK   (clk),
        .MEM_RST   (rst),
        .MEM_ADDR1 (addr1),
        .MEM_READ1 (read1),
        .MEM_DOUT1 (dout1),
        .MEM_ADDR2 (addr2),
        .MEM_DIN2  (din2),
        .MEM_WRITE2(write2),
        .MEM_READ2 (read2),
        .MEM_SIZE  (size),
        .MEM_SIGN  (sign),
        .MEM_DOUT2 (dout2),
        .IO_IN     (io_in),
        .IO_WR     (io_wr),
        .ERR       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a1, input logic r1, input logic [31:0] a2,
                         input logic [31:0] d2, input logic w2, input logic r2,
                         input logic [1:0] sz, input logic sg, input logic [31:0] ioi);
        @(negedge clk);
        addr1 = a1; read1 = r1; addr2 = a2; din2 = d2; write2 = w2; read2 = r2;
        size = sz; sign = sg; io_in = ioi;
    endtask

    typedef struct {
        logic [31:0] a1;
        logic        r1;
        logic [31:0] a2;
        logic [31:0] d2;
        logic        w2;
        logic        r2;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] ioi;
        logic        e_err;
        logic        e_iowr;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic [31:0] a1, logic r1, logic [31:0] a2, logic [31:0] d2,
                                logic w2, logic r2, logic [1:0] sz, logic sg, logic [31:0] ioi,
                                logic e_err, logic e_iowr, logic [31:0] e_d1, logic [31:0] e_d2);
        vec_t v;
        v.a1 = a1; v.r1 = r1; v.a2 = a2; v.d2 = d2; v.w2 = w2; v.r2 = r2;
        v.sz = sz; v.sg = sg; v.ioi = ioi; v.e_err = e_err; v.e_iowr = e_iowr;
        v.e_d1 = e_d1; v.e_d2 = e_d2;
        return v;
    endfunction

    // Reference model: 128-word window, behaviour written straight from the access rules.
    logic [31:0] m_mem [128];

    function automatic logic [31:0] model_load(logic [31:0] word, logic [1:0] off,
                                               logic [1:0] sz, logic sg);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (word >> (8 * off)) & 32'h0000_00FF;
            if (!sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (word >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (!sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic model_err(logic [31:0] a1, logic r1, logic [31:0] a2,
                                       logic w2, logic r2, logic [1:0] sz);
        logic e;
        e = r1 && (a1 % 4 != 0);
        if (w2 || r2) begin
            if (sz == 2'd3) e = 1'b1;
            if (sz == 2'd1 && (a2 % 2 != 0)) e = 1'b1;
            if (sz == 2'd2 && (a2 % 4 != 0)) e = 1'b1;
        end
        return e;
    endfunction

    task automatic model_store(input logic [31:0] a2, input logic [31:0] d2, input logic [1:0] sz);
        int w;
        int off;
        w   = (a2 / 4) % 128;
        off = a2 % 4;
        for (int lane = 0; lane < 4; lane++) begin
            if (sz == 2'd2)
                m_mem[w][8*lane +: 8] = d2[8*lane +: 8];
            else if (sz == 2'd1 && (lane / 2) == (off / 2))
                m_mem[w][8*lane +: 8] = d2[8*(lane % 2) +: 8];
            else if (sz == 2'd0 && lane == off)
                m_mem[w][8*lane +: 8] = d2[7:0];
        end
    endtask

    initial begin
        logic [31:0] a1, a2, d2, ioi, e_d1, e_d2, rnd;
        logic        r1, r2, w2, sg, is_io, e_err, m_v1, m_v2;
        logic [1:0]  sz;

        rst = 1'b1;
        addr1 = '0; read1 = 1'b0; addr2 = '0; din2 = '0; write2 = 1'b0; read2 = 1'b0;
        size = 2'd0; sign = 1'b0; io_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset_dout1", dout1, 32'h0);
        check32("reset_dout2", dout2, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int w = 0; w < 128; w++) drive('0, 1'b0, w * 4, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, '0);

        vecs[0]  = mk('0, 0, 32'h100, 32'hDEAD_BEEF, 1, 0, 2, 0, 0,            0, 0, 32'h0,         32'h0);
        vecs[1]  = mk(32'h100, 1, '0, 0, 0, 0, 2, 0, 0,                        0, 0, 32'hDEAD_BEEF, 32'h0);
        vecs[2]  = mk('0, 0, 32'h101, 0, 0, 1, 0, 0, 0,                        0, 0, 32'hDEAD_BEEF, 32'hFFFF_FFBE);
        vecs[3]  = mk('0, 0, 32'h101, 0, 0, 1, 0, 1, 0,                        0, 0, 32'hDEAD_BEEF, 32'h0000_00BE);
        vecs[4]  = mk('0, 0, 32'h102, 0, 0, 1, 1, 0, 0,                        0, 0, 32'hDEAD_BEEF, 32'hFFFF_DEAD);
        vecs[5]  = mk('0, 0, 32'h103, 32'hFFFF_FF55, 1, 0, 0, 0, 0,            0, 0, 32'hDEAD_BEEF, 32'hFFFF_DEAD);
        vecs[6]  = mk('0, 0, 32'h100, 0, 0, 1, 2, 0, 0,                        0, 0, 32'hDEAD_BEEF, 32'h55AD_BEEF);
        vecs[7]  = mk('0, 0, 32'h101, 32'h0000_1234, 1, 0, 1, 0, 0,            1, 0, 32'hDEAD_BEEF, 32'h55AD_BEEF);
        vecs[8]  = mk(32'h100, 1, 32'h100, 0, 0, 1, 2, 0, 0,                   0, 0, 32'h55AD_BEEF, 32'h55AD_BEEF);
        vecs[9]  = mk('0, 0, 32'h102, 0, 0, 1, 2, 0, 0,                        1, 0, 32'h55AD_BEEF, 32'h55AD_BEEF);
        vecs[10] = mk('0, 0, IO_BASE, 32'h1234_5678, 1, 0, 2, 0, 0,            0, 1, 32'h55AD_BEEF, 32'h55AD_BEEF);
        vecs[11] = mk('0, 0, IO_BASE, 0, 0, 1, 0, 0, 32'hCAFE_F00D,            0, 0, 32'h55AD_BEEF, 32'hCAFE_F00D);
        vecs[12] = mk('0, 0, 32'h0, 0, 0, 1, 2, 0, 0,                          0, 0, 32'h55AD_BEEF, 32'h0);
        vecs[13] = mk(32'h102, 1, '0, 0, 0, 0, 2, 0, 0,                        1, 0, 32'h55AD_BEEF, 32'h0);
        vecs[14] = mk('0, 0, 32'h100, 32'h0, 1, 0, 3, 0, 0,                    1, 0, 32'h55AD_BEEF, 32'h0);
        vecs[15] = mk('0, 0, 32'h1_0100, 0, 0, 1, 2, 0, 0,                     0, 0, 32'h55AD_BEEF, 32'h55AD_BEEF);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].a1, vecs[i].r1, vecs[i].a2, vecs[i].d2, vecs[i].w2, vecs[i].r2,
                  vecs[i].sz, vecs[i].sg, vecs[i].ioi);
            #1;
            check32($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].e_err});
            check32($sformatf("vec%0d_io_wr", i), {31'b0, io_wr}, {31'b0, vecs[i].e_iowr});
            @(posedge clk);
            #1;
            check32($sformatf("vec%0d_dout1", i), dout1, vecs[i].e_d1);
            check32($sformatf("vec%0d_dout2", i), dout2, vecs[i].e_d2);
        end

        // Mid-sequence reset: outputs clear at once, a write under reset is dropped.
        @(negedge clk);
        read1 = 1'b0; read2 = 1'b0; write2 = 1'b0;
        rst = 1'b1;
        #1;
        check32("async_rst_dout1", dout1, 32'h0);
        check32("async_rst_dout2", dout2, 32'h0);
        drive('0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, '0);
        @(negedge clk);
        write2 = 1'b0;
        rst = 1'b0;
        drive(32'h100, 1'b1, 32'h100, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0, '0);
        @(posedge clk);
        #1;
        check32("post_rst_dout1", dout1, 32'h55AD_BEEF);
        check32("post_rst_dout2", dout2, 32'h55AD_BEEF);

        // Same-cycle write and reads of one word return the old contents.
        drive(32'h100, 1'b1, 32'h100, 32'hA5A5_A5A5, 1'b1, 1'b1, 2'd2, 1'b0, '0);
        @(posedge clk);
        #1;
        check32("rdfirst_dout1", dout1, 32'h55AD_BEEF);
        check32("rdfirst_dout2", dout2, 32'h55AD_BEEF);
        drive(32'h100, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, '0);
        @(posedge clk);
        #1;
        check32("after_wr_dout1", dout1, 32'hA5A5_A5A5);
        check32("hold_dout2", dout2, 32'h55AD_BEEF);

        // Randomized phase: seed the window, then mixed traffic.
        for (int w = 0; w < 128; w++) begin
            rnd = $urandom;
            m_mem[w] = rnd;
            drive('0, 1'b0, w * 4, rnd, 1'b1, 1'b0, 2'd2, 1'b0, '0);
        end
        m_v1 = 1'b0; m_v2 = 1'b0; e_d1 = '0; e_d2 = '0;

        for (int it = 0; it < 1500; it++) begin
            r1 = ($urandom_range(0, 1) == 1);
            a1 = ($urandom_range(0, 7) << 16) | ($urandom_range(0, 127) * 4);
            if ($urandom_range(0, 7) == 0) a1 = a1 | $urandom_range(1, 3);
            is_io = ($urandom_range(0, 5) == 0);
            if (is_io) a2 = IO_BASE + $urandom_range(0, 1023);
            else       a2 = ($urandom_range(0, 15) << 16) | $urandom_range(0, 511);
            d2  = $urandom;
            ioi = $urandom;
            sz  = 2'($urandom_range(0, 3));
            sg  = ($urandom_range(0, 1) == 1);
            w2  = ($urandom_range(0, 2) == 0);
            r2  = (sz != 2'd3) && ($urandom_range(0, 1) == 1);
            e_err = model_err(a1, r1, a2, w2, r2, sz);

            drive(a1, r1, a2, d2, w2, r2, sz, sg, ioi);
            #1;
            check32("rand_err", {31'b0, err}, {31'b0, e_err});
            check32("rand_io_wr", {31'b0, io_wr}, {31'b0, w2 && is_io});

            if (r1) begin
                e_d1 = m_mem[(a1 / 4) % 128];
                m_v1 = 1'b1;
            end
            if (r2) begin
                e_d2 = is_io ? ioi : model_load(m_mem[(a2 / 4) % 128], 2'(a2 % 4), sz, sg);
                m_v2 = 1'b1;
            end
            if (w2 && !is_io && !model_err('0, 1'b0, a2, 1'b1, 1'b0, sz)) model_store(a2, d2, sz);

            @(posedge clk);
            #1;
            if (m_v1) check32("rand_dout1", dout1, e_d1);
            if (m_v2) check32("rand_dout2", dout2, e_d2);
        end

        @(negedge clk);
        read1 = 1'b0; read2 = 1'b0; write2 = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
